input_debounce: RTL and testbench



---
 rtl/input_debounce_pkg.sv | 15 +
 rtl/debounce_channel.sv | 67 ++++++
 rtl/input_debounce.sv | 36 +++
 tb/tb_input_debounce.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/input_debounce_pkg.sv
// Shared constants and helpers for the input debounce block.
// Default depths plus the stability-counter width function.
package input_debounce_pkg;

   localparam int DEB_SYNC_STAGES_DEF   = 2;
   localparam int DEB_STABLE_CYCLES_DEF = 4;

   // At least one bit, even when STABLE_CYCLES is 1 or 2.
   function automatic int deb_cnt_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: synchronizer, stability counter,
// registered level and registered rise/fall strobes.
module debounce_channel
   import input_debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = DEB_SYNC_STAGES_DEF,
   parameter int STABLE_CYCLES = DEB_STABLE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = deb_cnt_w(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_nxt;
   logic                   dout_nxt;
   logic                   rise_nxt;
   logic                   fall_nxt;
   logic                   s;
   logic                   same;
   logic                   done;

   assign s    = sync[SYNC_STAGES-1];
   assign same = (s == dout);
   assign done = !same && (cnt == CNT_MAX);

   always_comb begin
      cnt_nxt  = cnt;
      dout_nxt = dout;
      rise_nxt = 1'b0;
      fall_nxt = 1'b0;
      unique case (1'b1)
         same: cnt_nxt = '0;
         done: begin
            dout_nxt = s;
            cnt_nxt  = '0;
            rise_nxt = s;
            fall_nxt = ~s;
         end
         default: cnt_nxt = cnt + 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
         cnt  <= '0;
         dout <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         cnt  <= cnt_nxt;
         dout <= dout_nxt;
         rise <= rise_nxt;
         fall <= fall_nxt;
      end
   end

endmodule

// File: rtl/input_debounce.sv
// Multi-channel input conditioner: independent debounce lanes
// producing clean levels and one-cycle edge strobes.
module input_debounce
   import input_debounce_pkg::*;
#(
   parameter int CHANNELS      = 2,
   parameter int SYNC_STAGES   = DEB_SYNC_STAGES_DEF,
   parameter int STABLE_CYCLES = DEB_STABLE_CYCLES_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] din,
   output logic [CHANNELS-1:0] dout,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall
);

   if (CHANNELS < 1 || SYNC_STAGES < 2 || STABLE_CYCLES < 1) begin : g_bad_param
      $error("input_debounce: parameter below minimum");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES  (SYNC_STAGES),
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_ch (
         .clk (clk),
         .rst (rst),
         .din (din[i]),
         .dout(dout[i]),
         .rise(rise[i]),
         .fall(fall[i])
      );
   end

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: latency, glitch, bounce,
// fall, reset mid-count, AND-stage feed and STABLE_CYCLES=1.
module tb_input_debounce;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] din = 2'b00;
   logic [1:0] dout;
   logic [1:0] rise;
   logic [1:0] fall;
   logic       din1 = 1'b0;
   logic       dout1;
   logic       rise1;
   logic       fall1;
   logic       y;

   int n_cmp = 0;
   int n_err = 0;

   input_debounce #(.CHANNELS(2), .SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .din (din),
      .dout(dout),
      .rise(rise),
      .fall(fall)
   );

   input_debounce #(.CHANNELS(1), .SYNC_STAGES(2), .STABLE_CYCLES(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .din (din1),
      .dout(dout1),
      .rise(rise1),
      .fall(fall1)
   );

   // Downstream two-input AND stage fed by dout[0]/dout[1].
   assign y = dout[0] & dout[1];

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [1:0] dv;
      logic e0;
      logic e1;

      // Reset state
      rst = 1'b1;
      din = 2'b00;
      step(2);
      check("rst_dout", 8'(dout), 8'h0);
      check("rst_rise", 8'(rise), 8'h0);
      check("rst_fall", 8'(fall), 8'h0);

      // Release with din already 11: rise on edge 6
      din = 2'b11;
      step(1);
      rst = 1'b0;
      step(5);
      check("rel_dout_e5", 8'(dout), 8'h0);
      check("rel_rise_e5", 8'(rise), 8'h0);
      step(1);
      check("rel_dout_e6", 8'(dout), 8'h3);
      check("rel_rise_e6", 8'(rise), 8'h3);
      check("rel_fall_e6", 8'(fall), 8'h0);
      step(1);
      check("rel_rise_e7", 8'(rise), 8'h0);
      check("rel_dout_e7", 8'(dout), 8'h3);

      // Fall path on channel 0 only
      din = 2'b10;
      step(5);
      check("fall_dout_e5", 8'(dout), 8'h3);
      check("fall_fall_e5", 8'(fall), 8'h0);
      step(1);
      check("fall_dout_e6", 8'(dout), 8'h2);
      check("fall_fall_e6", 8'(fall), 8'h1);
      check("fall_rise_e6", 8'(rise), 8'h0);
      step(1);
      check("fall_fall_e7", 8'(fall), 8'h0);

      // Glitch: din[0] high 3 cycles
      din = 2'b11;
      for (int k = 0; k < 3; k++) begin
         step(1);
         check("glitch_dout", 8'(dout), 8'h2);
      end
      din = 2'b10;
      for (int k = 0; k < 8; k++) begin
         step(1);
         check("glitch_dout", 8'(dout), 8'h2);
         check("glitch_rise", 8'(rise), 8'h0);
         check("glitch_fall", 8'(fall), 8'h0);
      end

      // Bounce on channel 1 from a clean reset
      rst = 1'b1;
      din = 2'b00;
      step(2);
      rst = 1'b0;
      dv = 2'b10;
      for (int k = 0; k < 4; k++) begin
         din = dv;
         step(1);
         check("bounce_dout", 8'(dout), 8'h0);
         check("bounce_rise", 8'(rise), 8'h0);
         dv = dv ^ 2'b10;
      end
      din = 2'b10;
      step(5);
      check("bounce_dout_e5", 8'(dout), 8'h0);
      check("bounce_rise_e5", 8'(rise), 8'h0);
      step(1);
      check("bounce_dout_e6", 8'(dout), 8'h2);
      check("bounce_rise_e6", 8'(rise), 8'h2);
      for (int k = 0; k < 4; k++) begin
         step(1);
         check("bounce_rise_after", 8'(rise), 8'h0);
         check("bounce_dout_after", 8'(dout), 8'h2);
      end

      // Reset mid-count: cnt[0]=2 after edge 4
      din = 2'b11;
      step(4);
      check("midrst_dout_pre", 8'(dout), 8'h2);
      rst = 1'b1;
      step(1);
      check("midrst_dout", 8'(dout), 8'h0);
      check("midrst_rise", 8'(rise), 8'h0);
      rst = 1'b0;
      step(5);
      check("midrst_dout_e5", 8'(dout), 8'h0);
      step(1);
      check("midrst_dout_e6", 8'(dout), 8'h3);
      check("midrst_rise_e6", 8'(rise), 8'h3);

      // AND-stage feed: 01, 10, 11, 00 held 10 cycles each
      rst = 1'b1;
      din = 2'b00;
      step(2);
      rst = 1'b0;
      for (int k = 1; k <= 44; k++) begin
         if (k <= 10)      din = 2'b01;
         else if (k <= 20) din = 2'b10;
         else if (k <= 30) din = 2'b11;
         else              din = 2'b00;
         step(1);
         e0 = (k >= 6 && k < 16) || (k >= 26 && k < 36);
         e1 = (k >= 16 && k < 36);
         check("and_dout", 8'(dout), 8'({e1, e0}));
         check("and_y", 8'(y), 8'(e0 & e1));
      end

      // STABLE_CYCLES=1: dout follows s one register later
      rst = 1'b1;
      din1 = 1'b1;
      step(1);
      rst = 1'b0;
      step(2);
      check("sc1_dout_e2", 8'(dout1), 8'h0);
      step(1);
      check("sc1_dout_e3", 8'(dout1), 8'h1);
      check("sc1_rise_e3", 8'(rise1), 8'h1);
      step(1);
      check("sc1_rise_e4", 8'(rise1), 8'h0);
      din1 = 1'b0;
      step(2);
      check("sc1_dout_f2", 8'(dout1), 8'h1);
      step(1);
      check("sc1_dout_f3", 8'(dout1), 8'h0);
      check("sc1_fall_f3", 8'(fall1), 8'h1);
      step(1);
      check("sc1_fall_f4", 8'(fall1), 8'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
